// File: rtl/nes_pkt_parser.sv
// nes_pkt_parser: reads a stored Ethernet frame from the RX word store,
// checks the 7-word header (dest MAC, src MAC, EtherType) and forwards the
// payload words, indexed, to the NES-side loader; otherwise the frame is
// drained and dropped.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   frame_ready       pulse: a complete frame is stored upstream
//   axiiv, axiid      upstream word valid / 16-bit word
//   read_request      held high while the stored frame is streamed
//   payload_valid     payload word strobe (payload_data, payload_idx)
//   pkt_done, pkt_len accepted frame finished, payload words forwarded
//   pkt_drop, drop_reason  frame rejected: 1 dest MAC, 2 EtherType, 3 runt/timeout
module nes_pkt_parser #(
  parameter logic [47:0] MY_MAC            = 48'h0000_0000_0000,
  parameter logic        MAC_FILTER_EN     = 1'b1,
  parameter logic [15:0] ETHERTYPE         = 16'h88B5,
  parameter int unsigned MAX_PAYLOAD_WORDS = 128,
  parameter int unsigned TIMEOUT           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_ready,
  input  logic        axiiv,
  input  logic [15:0] axiid,
  output logic        read_request,
  output logic        payload_valid,
  output logic [15:0] payload_data,
  output logic [7:0]  payload_idx,
  output logic        pkt_done,
  output logic        pkt_drop,
  output logic [1:0]  drop_reason,
  output logic [7:0]  pkt_len
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_HDR  = 3'd2;
  localparam logic [2:0] ST_PAY  = 3'd3;
  localparam logic [2:0] ST_DROP = 3'd4;
  localparam logic [2:0] ST_GAP  = 3'd5;

  localparam logic [7:0] MAX_W   = 8'(MAX_PAYLOAD_WORDS);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] RSN_MAC   = 2'd1;
  localparam logic [1:0] RSN_ETYPE = 2'd2;
  localparam logic [1:0] RSN_RUNT  = 2'd3;

  logic [2:0]  state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [2:0]  hc_q, hc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gap_q, gap_d;
  logic        mac_mis_q, mac_mis_d;
  logic        bc_mis_q, bc_mis_d;
  logic [1:0]  reason_lat_q, reason_lat_d;
  logic        read_request_q, read_request_d;
  logic        payload_valid_q, payload_valid_d;
  logic [15:0] payload_data_q, payload_data_d;
  logic [7:0]  payload_idx_q, payload_idx_d;
  logic        pkt_done_q, pkt_done_d;
  logic        pkt_drop_q, pkt_drop_d;
  logic [1:0]  drop_reason_q, drop_reason_d;
  logic [7:0]  pkt_len_q, pkt_len_d;

  // Header word position: the first word is taken while still in WAIT.
  logic [2:0]  hdr_idx;
  logic [15:0] my_word;
  logic        mac_mis_w, bc_mis_w, dest_bad;

  always_comb begin
    hdr_idx = (state_q == ST_WAIT) ? 3'd0 : hc_q;
    case (hdr_idx)
      3'd0:    my_word = MY_MAC[47:32];
      3'd1:    my_word = MY_MAC[31:16];
      default: my_word = MY_MAC[15:0];
    endcase
    // Running mismatch flags against our address and against broadcast;
    // they restart with the first dest word of each frame.
    mac_mis_w = ((hdr_idx == 3'd0) ? 1'b0 : mac_mis_q) | (axiid != my_word);
    bc_mis_w  = ((hdr_idx == 3'd0) ? 1'b0 : bc_mis_q)  | (axiid != 16'hFFFF);
    dest_bad  = mac_mis_w & bc_mis_w & MAC_FILTER_EN;
  end

  // Next-state and output logic.
  always_comb begin
    logic hdr_step;
    logic end_runt;

    state_d         = state_q;
    timer_d         = timer_q;
    hc_d            = hc_q;
    cnt_d           = cnt_q;
    gap_d           = 1'b0;
    mac_mis_d       = mac_mis_q;
    bc_mis_d        = bc_mis_q;
    reason_lat_d    = reason_lat_q;
    read_request_d  = read_request_q;
    payload_valid_d = 1'b0;
    payload_data_d  = payload_data_q;
    payload_idx_d   = payload_idx_q;
    pkt_done_d      = 1'b0;
    pkt_drop_d      = 1'b0;
    drop_reason_d   = drop_reason_q;
    pkt_len_d       = pkt_len_q;
    hdr_step        = 1'b0;
    end_runt        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_ready) begin
          state_d        = ST_WAIT;
          read_request_d = 1'b1;
          timer_d        = 8'd0;
        end
      end
      ST_WAIT: begin
        if (axiiv) begin
          hdr_step = 1'b1;
        end else if (timer_q == TO_LAST) begin
          end_runt = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_HDR: begin
        if (axiiv) hdr_step = 1'b1;
        else       end_runt = 1'b1;
      end
      ST_PAY: begin
        if (axiiv) begin
          // Words past the limit are consumed but not forwarded.
          if (cnt_q < MAX_W) begin
            payload_valid_d = 1'b1;
            payload_data_d  = axiid;
            payload_idx_d   = cnt_q;
            cnt_d           = cnt_q + 8'd1;
          end
        end else begin
          pkt_done_d     = 1'b1;
          pkt_len_d      = cnt_q;
          read_request_d = 1'b0;
          state_d        = ST_GAP;
        end
      end
      ST_DROP: begin
        if (!axiiv) begin
          pkt_drop_d     = 1'b1;
          drop_reason_d  = reason_lat_q;
          read_request_d = 1'b0;
          state_d        = ST_GAP;
        end
      end
      ST_GAP: begin
        // Two idle cycles with read_request low let upstream rewind.
        if (gap_q) state_d = ST_IDLE;
        else       gap_d   = 1'b1;
      end
      default: begin
        state_d        = ST_IDLE;
        read_request_d = 1'b0;
      end
    endcase

    if (end_runt) begin
      pkt_drop_d     = 1'b1;
      drop_reason_d  = RSN_RUNT;
      read_request_d = 1'b0;
      state_d        = ST_GAP;
    end

    // Consume one header word.
    if (hdr_step) begin
      state_d = ST_HDR;
      hc_d    = hdr_idx + 3'd1;
      if (hdr_idx <= 3'd2) begin
        mac_mis_d = mac_mis_w;
        bc_mis_d  = bc_mis_w;
        if (hdr_idx == 3'd2 && dest_bad) begin
          state_d      = ST_DROP;
          reason_lat_d = RSN_MAC;
        end
      end else if (hdr_idx == 3'd6) begin
        if (axiid != ETHERTYPE) begin
          state_d      = ST_DROP;
          reason_lat_d = RSN_ETYPE;
        end else begin
          state_d = ST_PAY;
          cnt_d   = 8'd0;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      timer_q         <= 8'd0;
      hc_q            <= 3'd0;
      cnt_q           <= 8'd0;
      gap_q           <= 1'b0;
      mac_mis_q       <= 1'b0;
      bc_mis_q        <= 1'b0;
      reason_lat_q    <= 2'd0;
      read_request_q  <= 1'b0;
      payload_valid_q <= 1'b0;
      payload_data_q  <= 16'd0;
      payload_idx_q   <= 8'd0;
      pkt_done_q      <= 1'b0;
      pkt_drop_q      <= 1'b0;
      drop_reason_q   <= 2'd0;
      pkt_len_q       <= 8'd0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      hc_q            <= hc_d;
      cnt_q           <= cnt_d;
      gap_q           <= gap_d;
      mac_mis_q       <= mac_mis_d;
      bc_mis_q        <= bc_mis_d;
      reason_lat_q    <= reason_lat_d;
      read_request_q  <= read_request_d;
      payload_valid_q <= payload_valid_d;
      payload_data_q  <= payload_data_d;
      payload_idx_q   <= payload_idx_d;
      pkt_done_q      <= pkt_done_d;
      pkt_drop_q      <= pkt_drop_d;
      drop_reason_q   <= drop_reason_d;
      pkt_len_q       <= pkt_len_d;
    end
  end

  assign read_request  = read_request_q;
  assign payload_valid = payload_valid_q;
  assign payload_data  = payload_data_q;
  assign payload_idx   = payload_idx_q;
  assign pkt_done      = pkt_done_q;
  assign pkt_drop      = pkt_drop_q;
  assign drop_reason   = drop_reason_q;
  assign pkt_len       = pkt_len_q;

endmodule

// File: tb/tb_nes_pkt_parser.sv
// tb_nes_pkt_parser: directed test of nes_pkt_parser. Instance a uses the
// default payload limit, instance b a limit of 4; both share the word stream.
module tb_nes_pkt_parser;

  localparam logic [47:0] MAC = 48'h0102_0304_0506;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fr_a, fr_b, axiiv;
  logic [15:0] axiid;

  logic        a_rr, a_pv, a_done, a_drop;
  logic [15:0] a_pd;
  logic [7:0]  a_pi, a_len;
  logic [1:0]  a_reason;
  logic        b_rr, b_pv, b_done, b_drop;
  logic [15:0] b_pd;
  logic [7:0]  b_pi, b_len;
  logic [1:0]  b_reason;

  nes_pkt_parser #(.MY_MAC(MAC)) dut_a (
    .clk(clk), .rst(rst), .frame_ready(fr_a), .axiiv(axiiv), .axiid(axiid),
    .read_request(a_rr), .payload_valid(a_pv), .payload_data(a_pd),
    .payload_idx(a_pi), .pkt_done(a_done), .pkt_drop(a_drop),
    .drop_reason(a_reason), .pkt_len(a_len)
  );

  nes_pkt_parser #(.MY_MAC(MAC), .MAX_PAYLOAD_WORDS(4)) dut_b (
    .clk(clk), .rst(rst), .frame_ready(fr_b), .axiiv(axiiv), .axiid(axiid),
    .read_request(b_rr), .payload_valid(b_pv), .payload_data(b_pd),
    .payload_idx(b_pi), .pkt_done(b_done), .pkt_drop(b_drop),
    .drop_reason(b_reason), .pkt_len(b_len)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Event log, sampled just after each rising edge.
  logic [15:0] a_pv_data [0:63];
  logic [7:0]  a_pv_idx  [0:63];
  logic [15:0] b_pv_data [0:63];
  logic [7:0]  b_pv_idx  [0:63];
  int a_pv_n = 0, a_done_n = 0, a_drop_n = 0;
  int b_pv_n = 0, b_done_n = 0, b_drop_n = 0;

  always begin
    @(posedge clk);
    #1;
    if (a_pv) begin
      if (a_pv_n < 64) begin a_pv_data[a_pv_n] = a_pd; a_pv_idx[a_pv_n] = a_pi; end
      a_pv_n++;
    end
    if (b_pv) begin
      if (b_pv_n < 64) begin b_pv_data[b_pv_n] = b_pd; b_pv_idx[b_pv_n] = b_pi; end
      b_pv_n++;
    end
    if (a_done) a_done_n++;
    if (a_drop) a_drop_n++;
    if (b_done) b_done_n++;
    if (b_drop) b_drop_n++;
  end

  logic [15:0] frm [0:31];
  int frm_n = 0;

  task automatic set_hdr(input logic [47:0] dst, input logic [15:0] et);
    frm[0] = dst[47:32];
    frm[1] = dst[31:16];
    frm[2] = dst[15:0];
    frm[3] = 16'h1111;
    frm[4] = 16'h2222;
    frm[5] = 16'h3333;
    frm[6] = et;
    frm_n  = 7;
  endtask

  task automatic add_pay(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      frm[frm_n] = base + 16'(i);
      frm_n++;
    end
  endtask

  // Stream frm[] after a frame_ready pulse; lat = cycles from axiiv falling
  // (or from read_request rising for an empty stream) to the end pulse.
  task automatic send(input bit to_b, input int extra_fr_at, output int lat, output int rr_low);
    rr_low = 0;
    @(negedge clk);
    if (to_b) fr_b = 1'b1; else fr_a = 1'b1;
    @(negedge clk);
    fr_a = 1'b0;
    fr_b = 1'b0;
    for (int i = 0; i < frm_n; i++) begin
      axiiv = 1'b1;
      axiid = frm[i];
      if (i == extra_fr_at) fr_b = 1'b1;
      @(negedge clk);
      fr_b = 1'b0;
      if ((to_b ? b_rr : a_rr) == 1'b0) rr_low++;
    end
    axiiv = 1'b0;
    axiid = 16'h0;
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (to_b ? (b_done | b_drop) : (a_done | a_drop)) begin
        lat = k;
        break;
      end
    end
  endtask

  // read_request must stay low through the two cycles after the end pulse.
  task automatic gap_check(input string tag, input bit to_b);
    check({tag, "_gap0_rr"}, 32'(to_b ? b_rr : a_rr), 32'd0);
    @(negedge clk);
    check({tag, "_gap1_rr"}, 32'(to_b ? b_rr : a_rr), 32'd0);
  endtask

  int lat, rrl, s_pv, s_done, s_drop;

  initial begin
    rst   = 1'b1;
    fr_a  = 1'b0;
    fr_b  = 1'b0;
    axiiv = 1'b0;
    axiid = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rr",  32'(a_rr), 0);
    check("rst_pv",  32'(a_pv), 0);
    check("rst_pd",  32'(a_pd), 0);
    check("rst_pi",  32'(a_pi), 0);
    check("rst_evt", 32'({a_done, a_drop}), 0);
    check("rst_rsn", 32'(a_reason), 0);
    check("rst_len", 32'(a_len), 0);

    // Accepted frame with 4 payload words.
    set_hdr(MAC, 16'h88B5); add_pay(4, 16'hA000);
    s_pv = a_pv_n; s_done = a_done_n; s_drop = a_drop_n;
    send(1'b0, -1, lat, rrl);
    check("acc_pv_n", 32'(a_pv_n - s_pv), 4);
    for (int i = 0; i < 4; i++) begin
      check("acc_data", 32'(a_pv_data[s_pv + i]), 32'(16'hA000 + 16'(i)));
      check("acc_idx",  32'(a_pv_idx[s_pv + i]), 32'(i));
    end
    check("acc_done_n", 32'(a_done_n - s_done), 1);
    check("acc_drop_n", 32'(a_drop_n - s_drop), 0);
    check("acc_len", 32'(a_len), 4);
    check("acc_lat", 32'(lat), 1);
    check("acc_rr_hi", 32'(rrl), 0);
    gap_check("acc", 1'b0);

    // Broadcast destination accepted.
    set_hdr(48'hFFFF_FFFF_FFFF, 16'h88B5); add_pay(2, 16'hC000);
    s_pv = a_pv_n; s_done = a_done_n;
    send(1'b0, -1, lat, rrl);
    check("bc_pv_n", 32'(a_pv_n - s_pv), 2);
    check("bc_data1", 32'(a_pv_data[s_pv + 1]), 32'h0000C001);
    check("bc_done_n", 32'(a_done_n - s_done), 1);
    check("bc_len", 32'(a_len), 2);
    gap_check("bc", 1'b0);

    // Wrong destination: drained, dropped with reason 1.
    set_hdr(48'h0102_0304_0507, 16'h88B5); add_pay(3, 16'hD000);
    s_pv = a_pv_n; s_drop = a_drop_n;
    send(1'b0, -1, lat, rrl);
    check("mac_pv_n", 32'(a_pv_n - s_pv), 0);
    check("mac_drop_n", 32'(a_drop_n - s_drop), 1);
    check("mac_rsn", 32'(a_reason), 1);
    check("mac_rr_hi", 32'(rrl), 0);
    check("mac_lat", 32'(lat), 1);
    gap_check("mac", 1'b0);

    // Wrong EtherType: dropped with reason 2 after the drain.
    set_hdr(MAC, 16'h0800); add_pay(3, 16'hE000);
    s_pv = a_pv_n; s_drop = a_drop_n;
    send(1'b0, -1, lat, rrl);
    check("et_pv_n", 32'(a_pv_n - s_pv), 0);
    check("et_drop_n", 32'(a_drop_n - s_drop), 1);
    check("et_rsn", 32'(a_reason), 2);
    check("et_lat", 32'(lat), 1);
    gap_check("et", 1'b0);

    // Runt: only 4 header words.
    set_hdr(MAC, 16'h88B5); frm_n = 4;
    s_drop = a_drop_n; s_done = a_done_n;
    send(1'b0, -1, lat, rrl);
    check("runt_drop_n", 32'(a_drop_n - s_drop), 1);
    check("runt_done_n", 32'(a_done_n - s_done), 0);
    check("runt_rsn", 32'(a_reason), 3);
    check("runt_lat", 32'(lat), 1);
    gap_check("runt", 1'b0);

    // Empty header-only frame first clears the reason path, then timeout.
    set_hdr(MAC, 16'h88B5);
    s_done = a_done_n;
    send(1'b0, -1, lat, rrl);
    check("zero_done_n", 32'(a_done_n - s_done), 1);
    check("zero_len", 32'(a_len), 0);
    check("zero_rsn_hold", 32'(a_reason), 3);
    gap_check("zero", 1'b0);

    frm_n = 0;
    s_drop = a_drop_n;
    send(1'b0, -1, lat, rrl);
    check("to_drop_n", 32'(a_drop_n - s_drop), 1);
    check("to_rsn", 32'(a_reason), 3);
    check("to_lat", 32'(lat), 16);
    check("to_len_hold", 32'(a_len), 0);
    gap_check("to", 1'b0);

    // Payload limit 4 with 10 words; a second frame_ready mid-stream is ignored.
    set_hdr(MAC, 16'h88B5); add_pay(10, 16'h5000);
    s_pv = b_pv_n; s_done = b_done_n; s_drop = b_drop_n;
    send(1'b1, 12, lat, rrl);
    check("max_pv_n", 32'(b_pv_n - s_pv), 4);
    check("max_idx3", 32'(b_pv_idx[s_pv + 3]), 3);
    check("max_data3", 32'(b_pv_data[s_pv + 3]), 32'h00005003);
    check("max_len", 32'(b_len), 4);
    check("max_rsn", 32'(b_reason), 0);
    gap_check("max", 1'b1);
    repeat (25) @(negedge clk);
    check("max_done_n", 32'(b_done_n - s_done), 1);
    check("max_drop_n", 32'(b_drop_n - s_drop), 0);
    check("max_rr_idle", 32'(b_rr), 0);

    // Reset in the middle of the payload aborts without a pulse.
    set_hdr(MAC, 16'h88B5); add_pay(4, 16'hB000);
    s_done = a_done_n; s_drop = a_drop_n;
    @(negedge clk); fr_a = 1'b1;
    @(negedge clk); fr_a = 1'b0;
    for (int i = 0; i < 9; i++) begin
      axiiv = 1'b1;
      axiid = frm[i];
      @(negedge clk);
    end
    check("mid_pv_before", 32'(a_pv), 1);
    axiid = frm[9];
    rst   = 1'b1;
    @(negedge clk);
    check("mid_rr",  32'(a_rr), 0);
    check("mid_pv",  32'(a_pv), 0);
    check("mid_pd",  32'(a_pd), 0);
    check("mid_pi",  32'(a_pi), 0);
    check("mid_len", 32'(a_len), 0);
    check("mid_rsn", 32'(a_reason), 0);
    rst   = 1'b0;
    axiiv = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_done_n", 32'(a_done_n - s_done), 0);
    check("mid_drop_n", 32'(a_drop_n - s_drop), 0);

    // Next frame after the abort parses normally.
    set_hdr(MAC, 16'h88B5); add_pay(3, 16'h7000);
    s_pv = a_pv_n; s_done = a_done_n;
    send(1'b0, -1, lat, rrl);
    check("post_pv_n", 32'(a_pv_n - s_pv), 3);
    check("post_idx0", 32'(a_pv_idx[s_pv]), 0);
    check("post_data2", 32'(a_pv_data[s_pv + 2]), 32'h00007002);
    check("post_done_n", 32'(a_done_n - s_done), 1);
    check("post_len", 32'(a_len), 3);
    gap_check("post", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
